// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] if_inst_o,
    output logic        if_done_o,
    output logic [31:0] mem_data_o,
    output logic        mem_done_o,
    output logic        stallreq_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ready_i
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IF_BUSY  = 2'd1;
    localparam logic [1:0] MEM_BUSY = 2'd2;
    localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);

    logic [1:0] state;
    logic [2:0] starve_cnt;
    logic       turnaround;
    logic       grant_if;
    logic       grant_mem;
    logic       capture;

    // Arbitration: nothing is granted on a done cycle; IF wins a tie only once MEM has starved it
    always_comb begin
        turnaround = if_done_o | mem_done_o;
        grant_if   = (state == IDLE) && !turnaround && if_req_i &&
                     (!mem_req_i || starve_cnt == LIMIT);
        grant_mem  = (state == IDLE) && !turnaround && mem_req_i && !grant_if;
        capture    = (state != IDLE) && bus_ready_i;
    end

    assign stallreq_o = (if_req_i | mem_req_i) & ~(if_done_o | mem_done_o);

    // Sequencer and bus registers: latched on grant, frozen while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus_ce_o   <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_addr_o <= 32'h0;
            bus_sel_o  <= 4'h0;
            bus_data_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state      <= IF_BUSY;
                        bus_ce_o   <= 1'b1;
                        bus_we_o   <= 1'b0;
                        bus_addr_o <= if_addr_i;
                        bus_sel_o  <= 4'hF;
                        bus_data_o <= 32'h0;
                    end else if (grant_mem) begin
                        state      <= MEM_BUSY;
                        bus_ce_o   <= 1'b1;
                        bus_we_o   <= mem_we_i;
                        bus_addr_o <= mem_addr_i;
                        bus_sel_o  <= mem_sel_i;
                        bus_data_o <= mem_data_i;
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (bus_ready_i) begin
                        state    <= IDLE;
                        bus_ce_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus_ce_o <= 1'b0;
                end
            endcase
        end
    end

    // Results and one-cycle completion pulses; write completions leave mem_data_o untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            if_inst_o  <= 32'h0;
            if_done_o  <= 1'b0;
            mem_data_o <= 32'h0;
            mem_done_o <= 1'b0;
        end else begin
            if_done_o  <= capture && (state == IF_BUSY);
            mem_done_o <= capture && (state == MEM_BUSY);
            if (capture && state == IF_BUSY)
                if_inst_o <= bus_data_i;
            if (capture && state == MEM_BUSY && !bus_we_o)
                mem_data_o <= bus_data_i;
        end
    end

    // Starvation counter: consecutive MEM grants while IF is waiting, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= 3'd0;
        else if (grant_if || (state == IDLE && !if_req_i))
            starve_cnt <= 3'd0;
        else if (grant_mem && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 3'd1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] if_inst_o;
    logic        if_done_o;
    logic [31:0] mem_data_o;
    logic        mem_done_o;
    logic        stallreq_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ready_i;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
        .if_inst_o(if_inst_o), .if_done_o(if_done_o),
        .mem_data_o(mem_data_o), .mem_done_o(mem_done_o),
        .stallreq_o(stallreq_o),
        .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
        .bus_data_i(bus_data_i), .bus_ready_i(bus_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory behind the bus (driven by what the DUT actually emits) and the model's own copy
    logic [31:0] slave_mem [256];
    logic [31:0] ref_mem   [256];

    // model: the transaction in flight (0 none, 1 fetch, 2 data) and what the port should show
    int          owner;
    int          starve;
    logic        e_ce, e_we, e_ifd, e_md;
    logic [31:0] e_addr, e_wd, e_inst, e_mdata;
    logic [3:0]  e_sel;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // next-cycle expectations from the arbitration rules, given the inputs about to be sampled
    task automatic model_update;
        logic busy_done;
        busy_done = e_ifd | e_md;
        if (rst) begin
            owner = 0; starve = 0;
            e_ce = 0; e_we = 0; e_ifd = 0; e_md = 0;
            e_addr = 0; e_wd = 0; e_inst = 0; e_mdata = 0; e_sel = 0;
        end else begin
            e_ifd = 0;
            e_md  = 0;
            if (owner != 0) begin
                if (bus_ready_i) begin
                    if (owner == 1) begin
                        e_inst = ref_mem[e_addr[9:2]];
                        e_ifd  = 1;
                    end else begin
                        if (e_we) ref_mem[e_addr[9:2]] = merge(ref_mem[e_addr[9:2]], e_wd, e_sel);
                        else      e_mdata = ref_mem[e_addr[9:2]];
                        e_md = 1;
                    end
                    e_ce  = 0;
                    owner = 0;
                end
            end else begin
                if (!if_req_i) starve = 0;
                if (!busy_done && if_req_i && (!mem_req_i || starve == LIMIT)) begin
                    owner = 1; e_ce = 1; e_we = 0; e_addr = if_addr_i; e_sel = 4'hF; e_wd = 0;
                    starve = 0;
                end else if (!busy_done && mem_req_i) begin
                    owner = 2; e_ce = 1; e_we = mem_we_i; e_addr = mem_addr_i;
                    e_sel = mem_sel_i; e_wd = mem_data_i;
                    if (if_req_i && starve < LIMIT) starve++;
                end
            end
        end
    endtask

    task automatic check_outputs;
        chk("bus_ce", bus_ce_o, e_ce);
        if (e_ce) begin
            chk("bus_addr", bus_addr_o, e_addr);
            chk("bus_we", bus_we_o, e_we);
            chk("bus_sel", bus_sel_o, e_sel);
        end
        if (e_ce && e_we) chk("bus_wdata", bus_data_o, e_wd);
        chk("if_done", if_done_o, e_ifd);
        chk("mem_done", mem_done_o, e_md);
        chk("if_inst", if_inst_o, e_inst);
        chk("mem_data", mem_data_o, e_mdata);
        chk("stallreq", stallreq_o, (if_req_i | mem_req_i) & ~(e_ifd | e_md));
    endtask

    // one clock: bus slave responds, model advances, outputs checked, finished requesters drop
    task automatic step;
        bus_data_i = bus_ce_o ? slave_mem[bus_addr_o[9:2]] : $urandom;
        if (!rst && bus_ce_o === 1'b1 && bus_we_o === 1'b1 && bus_ready_i)
            slave_mem[bus_addr_o[9:2]] = merge(slave_mem[bus_addr_o[9:2]], bus_data_o, bus_sel_o);
        model_update;
        @(negedge clk);
        check_outputs;
        if (if_done_o)  if_req_i  = 0;
        if (mem_done_o) mem_req_i = 0;
    endtask

    task automatic step_n(input int n);
        repeat (n) step;
    endtask

    task automatic rand_drive;
        if (!if_req_i && $urandom_range(0, 2) == 0) begin
            if_req_i  = 1;
            if_addr_i = {22'h0, 8'($urandom), 2'b00};
        end
        if (!mem_req_i && $urandom_range(0, 2) == 0) begin
            mem_req_i  = 1;
            mem_we_i   = 1'($urandom);
            mem_addr_i = {22'h0, 8'($urandom), 2'b00};
            mem_sel_i  = 4'($urandom_range(1, 15));
            mem_data_i = $urandom;
        end
        bus_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int nmem;
        int if_wait;
        int mem_wait;
        logic seen_if;
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            slave_mem[i] = v;
            ref_mem[i]   = v;
        end
        rst = 1; if_req_i = 0; if_addr_i = 0; mem_req_i = 0; mem_we_i = 0;
        mem_addr_i = 0; mem_sel_i = 0; mem_data_i = 0; bus_data_i = 0; bus_ready_i = 0;

        // reset state
        step_n(2);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_sel", bus_sel_o, 32'h0);
        chk("rst_we", bus_we_o, 32'h0);
        chk("rst_wdata", bus_data_o, 32'h0);
        rst = 0;

        // ready is ignored while idle
        bus_ready_i = 1;
        step_n(3);

        // fetch of 0x100 with ready tied high
        if_req_i = 1; if_addr_i = 32'h100;
        step;
        chk("f_ce", bus_ce_o, 1);
        chk("f_addr", bus_addr_o, 32'h100);
        chk("f_sel", bus_sel_o, 4'hF);
        step;
        chk("f_done", if_done_o, 1);
        chk("f_inst", if_inst_o, ref_mem[64]);
        step;
        chk("f_pulse_once", if_done_o, 0);
        chk("f_inst_hold", if_inst_o, ref_mem[64]);

        // simultaneous requests: data first, then fetch after a turnaround cycle
        if_req_i = 1; if_addr_i = 32'h180;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h1C0; mem_sel_i = 4'hF;
        step;
        chk("tie_mem_first", bus_addr_o, 32'h1C0);
        step;
        chk("tie_mem_done", mem_done_o, 1);
        chk("tie_stall_done", stallreq_o, 0);
        step;
        chk("tie_turnaround", bus_ce_o, 0);
        chk("tie_stall", stallreq_o, 1);
        step;
        chk("tie_if_grant", bus_addr_o, 32'h180);
        step;
        chk("tie_if_done", if_done_o, 1);
        step_n(2);

        // write 0x104 with three wait cycles, then read it back
        bus_ready_i = 0;
        mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h104; mem_sel_i = 4'b1000; mem_data_i = 32'h4100_0000;
        for (int c = 1; c <= 4; c++) begin
            step;
            mem_addr_i = 32'hDEAD_BEE0; mem_data_i = 32'h0; mem_sel_i = 4'h1;
            chk("wr_ce_stable", bus_ce_o, 1);
            chk("wr_addr_stable", bus_addr_o, 32'h104);
            chk("wr_sel_stable", bus_sel_o, 4'b1000);
            chk("wr_data_stable", bus_data_o, 32'h4100_0000);
        end
        bus_ready_i = 1;
        step;
        chk("wr_done_c5", mem_done_o, 1);
        step;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h104; mem_sel_i = 4'hF;
        step_n(2);
        chk("rd_back", mem_data_o, ref_mem[65]);
        chk("rd_back_byte", mem_data_o[31:24], 8'h41);
        step_n(2);

        // back-to-back data requests starve fetch for exactly LIMIT grants
        if_req_i = 1; if_addr_i = 32'h200;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
        nmem = 0; seen_if = 0;
        for (int i = 0; i < 60 && !seen_if; i++) begin
            step;
            if (if_done_o) seen_if = 1;
            else if (mem_done_o) begin
                nmem++;
                mem_req_i  = 1;
                mem_addr_i = 32'h300 + 32'(4 * nmem);
            end
        end
        chk("starve_if_seen", seen_if, 1);
        chk("starve_mem_grants", nmem, LIMIT);
        step_n(8);

        // request dropped mid-access still completes
        bus_ready_i = 0;
        mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h110; mem_sel_i = 4'hF;
        step;
        mem_req_i = 0;
        step_n(2);
        bus_ready_i = 1;
        step;
        chk("drop_done", mem_done_o, 1);
        step_n(2);

        // reset in the middle of a data access abandons it
        bus_ready_i = 0;
        mem_req_i = 1; mem_addr_i = 32'h108;
        step_n(2);
        rst = 1; mem_req_i = 0;
        step;
        chk("rst_busy_ce", bus_ce_o, 0);
        chk("rst_busy_done", mem_done_o, 0);
        chk("rst_busy_data", mem_data_o, 0);
        rst = 0; bus_ready_i = 1;
        if_req_i = 1; if_addr_i = 32'h10C;
        step_n(2);
        chk("post_rst_if_done", if_done_o, 1);
        chk("post_rst_if_inst", if_inst_o, ref_mem[67]);
        step_n(2);

        // random traffic
        if_wait = 0; mem_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            rand_drive;
            step;
            if (if_done_o) begin
                chk("if_latency", 32'(if_wait < 100), 1);
                if_wait = 0;
            end else if (if_req_i) if_wait++;
            if (mem_done_o) begin
                chk("mem_latency", 32'(mem_wait < 100), 1);
                mem_wait = 0;
            end else if (mem_req_i) mem_wait++;
        end
        chk("if_not_stuck", 32'(if_wait < 100), 1);
        chk("mem_not_stuck", 32'(mem_wait < 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
